// File: rtl/echo_feedback_tap.sv
// echo_feedback_tap
//   Echo generator with a circular sample buffer of 2**DEPTH_LOG2 entries.
//   Each accepted sample is mixed with the sample written delay_len_i samples
//   earlier. A feedback-weighted value is written back into the buffer.
//   One sample every 4 clocks. Latency is 3 clocks from acceptance to out_valid_o.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   S_IDLE  | wait for in_valid_i; latch sample, delay and gains
//   S_READ  | issue synchronous buffer read at wr_ptr - delay
//   S_MIX   | mask the tap, register both gain products
//   S_WRITE | saturate sums, update out_o and the buffer, advance ptr
//
// Ports
//   clk_i        system clock, posedge
//   reset_i      synchronous active-high reset
//   in_valid_i   one-cycle strobe, sample present on in_i
//   in_i         signed 32-bit input sample
//   delay_len_i  echo delay in samples (0 disables the tap)
//   mix_gain_i   Q0.GAIN_W weight of the delayed sample in out_o
//   fb_gain_i    Q0.GAIN_W weight of the delayed sample written back
//   out_valid_o  one-cycle strobe, out_o holds a new sample
//   out_o        signed 32-bit mixed sample, held between strobes
//   busy_o       high while a sample is in flight
//   overrun_o    sticky: a strobe arrived while busy and was dropped
module echo_feedback_tap #(
   parameter int DEPTH_LOG2 = 8,
   parameter int GAIN_W     = 8
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   input  logic                  in_valid_i,
   input  logic [31:0]           in_i,
   input  logic [DEPTH_LOG2-1:0] delay_len_i,
   input  logic [GAIN_W-1:0]     mix_gain_i,
   input  logic [GAIN_W-1:0]     fb_gain_i,
   output logic                  out_valid_o,
   output logic [31:0]           out_o,
   output logic                  busy_o,
   output logic                  overrun_o
);

   localparam int PW    = 32 + GAIN_W + 1;   // signed sample x zero-extended gain
   localparam int SW    = PW + 1;            // sum width with headroom
   localparam int DEPTH = 2 ** DEPTH_LOG2;

   typedef enum logic [1:0] {S_IDLE, S_READ, S_MIX, S_WRITE} state_t;

   state_t                  state_q, state_d;
   logic [DEPTH_LOG2-1:0]   wr_ptr_q, wr_ptr_d;
   logic [DEPTH_LOG2-1:0]   fill_q, fill_d;
   logic [31:0]             smp_q, smp_d;
   logic [DEPTH_LOG2-1:0]   dly_q, dly_d;
   logic [GAIN_W-1:0]       mixg_q, mixg_d;
   logic [GAIN_W-1:0]       fbg_q, fbg_d;
   logic signed [PW-1:0]    prod_mix_q, prod_mix_d;
   logic signed [PW-1:0]    prod_fb_q, prod_fb_d;
   logic [31:0]             out_q, out_d;
   logic                    out_valid_q, out_valid_d;
   logic                    overrun_q, overrun_d;
   logic [31:0]             rd_data_q;
   logic [31:0]             mem_q [DEPTH];

   logic [DEPTH_LOG2-1:0]   rd_addr;
   logic                    tap_en;
   logic [31:0]             delayed;
   logic signed [PW-1:0]    delayed_x;
   logic signed [PW-1:0]    mixg_x;
   logic signed [PW-1:0]    fbg_x;
   logic signed [PW-1:0]    mix_sh;
   logic signed [PW-1:0]    fb_sh;
   logic [SW-1:0]           sum_mix;
   logic [SW-1:0]           sum_fb;
   logic [31:0]             wr_data;
   logic                    ram_we;

   function automatic logic [31:0] sat32(input logic [SW-1:0] s);
      // In range only when every bit above bit 31 matches the sign bit.
      if (!s[SW-1] && (|s[SW-2:31])) begin
         return 32'h7FFF_FFFF;
      end else if (s[SW-1] && !(&s[SW-2:31])) begin
         return 32'h8000_0000;
      end else begin
         return s[31:0];
      end
   endfunction

   assign rd_addr = wr_ptr_q - dly_q;

   // fill counts samples written since reset, so stale RAM contents from
   // before a reset are never used as a tap.
   assign tap_en  = (dly_q != '0) && (fill_q >= dly_q);
   assign delayed = tap_en ? rd_data_q : 32'h0;

   assign delayed_x = {{(PW-32){delayed[31]}}, delayed};
   assign mixg_x    = {{(PW-GAIN_W){1'b0}}, mixg_q};
   assign fbg_x     = {{(PW-GAIN_W){1'b0}}, fbg_q};

   assign mix_sh  = prod_mix_q >>> GAIN_W;
   assign fb_sh   = prod_fb_q >>> GAIN_W;
   assign sum_mix = {{(SW-32){smp_q[31]}}, smp_q} + {mix_sh[PW-1], mix_sh};
   assign sum_fb  = {{(SW-32){smp_q[31]}}, smp_q} + {fb_sh[PW-1], fb_sh};
   assign wr_data = sat32(sum_fb);

   always_comb begin
      state_d     = state_q;
      wr_ptr_d    = wr_ptr_q;
      fill_d      = fill_q;
      smp_d       = smp_q;
      dly_d       = dly_q;
      mixg_d      = mixg_q;
      fbg_d       = fbg_q;
      prod_mix_d  = prod_mix_q;
      prod_fb_d   = prod_fb_q;
      out_d       = out_q;
      out_valid_d = 1'b0;
      ram_we      = 1'b0;
      overrun_d   = overrun_q | (in_valid_i && (state_q != S_IDLE));

      case (state_q)
         S_IDLE: begin
            if (in_valid_i) begin
               smp_d   = in_i;
               dly_d   = delay_len_i;
               mixg_d  = mix_gain_i;
               fbg_d   = fb_gain_i;
               state_d = S_READ;
            end
         end
         S_READ: begin
            state_d = S_MIX;
         end
         S_MIX: begin
            prod_mix_d = delayed_x * mixg_x;
            prod_fb_d  = delayed_x * fbg_x;
            state_d    = S_WRITE;
         end
         S_WRITE: begin
            out_d       = sat32(sum_mix);
            out_valid_d = 1'b1;
            ram_we      = 1'b1;
            wr_ptr_d    = wr_ptr_q + DEPTH_LOG2'(1);
            if (fill_q != '1) begin
               fill_d = fill_q + DEPTH_LOG2'(1);
            end
            state_d     = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q     <= S_IDLE;
         wr_ptr_q    <= '0;
         fill_q      <= '0;
         smp_q       <= '0;
         dly_q       <= '0;
         mixg_q      <= '0;
         fbg_q       <= '0;
         prod_mix_q  <= '0;
         prod_fb_q   <= '0;
         out_q       <= '0;
         out_valid_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         fill_q      <= fill_d;
         smp_q       <= smp_d;
         dly_q       <= dly_d;
         mixg_q      <= mixg_d;
         fbg_q       <= fbg_d;
         prod_mix_q  <= prod_mix_d;
         prod_fb_q   <= prod_fb_d;
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
         overrun_q   <= overrun_d;
      end
   end

   // Buffer is left uncleared by reset; a reset landing on S_WRITE suppresses
   // the write so an aborted sample never reaches the buffer.
   always_ff @(posedge clk_i) begin
      if (ram_we && !reset_i) begin
         mem_q[wr_ptr_q] <= wr_data;
      end
      if (state_q == S_READ) begin
         rd_data_q <= mem_q[rd_addr];
      end
   end

   assign out_o       = out_q;
   assign out_valid_o = out_valid_q;
   assign busy_o      = (state_q != S_IDLE);
   assign overrun_o   = overrun_q;

endmodule
